// File: rtl/tile_refresh_sched_if.sv
// Signal bundle between the frame scheduler, the game controller, the per-line
// erase/draw engines and the VGA write port.
interface tile_refresh_sched_if;
  logic        startn;
  logic        draw_go;
  logic [5:0]  dirty_mask;
  logic [5:0]  erase_done;
  logic [5:0]  draw_done;
  logic [53:0] erase_x;
  logic [47:0] erase_y;
  logic [5:0]  erase_color;
  logic [53:0] draw_x;
  logic [47:0] draw_y;
  logic [5:0]  draw_color;
  logic [5:0]  erase_en;
  logic [5:0]  draw_en;
  logic        vga_en;
  logic [8:0]  xOutput;
  logic [7:0]  yOutput;
  logic [2:0]  colorOutput;
  logic        isDrawingDone;
  logic        busy;
  logic        timeout_err;

  // The controller/engine environment side.
  modport master (
    output startn, draw_go, dirty_mask, erase_done, draw_done,
           erase_x, erase_y, erase_color, draw_x, draw_y, draw_color,
    input  erase_en, draw_en, vga_en, xOutput, yOutput, colorOutput,
           isDrawingDone, busy, timeout_err
  );

  // The scheduler side.
  modport slave (
    input  startn, draw_go, dirty_mask, erase_done, draw_done,
           erase_x, erase_y, erase_color, draw_x, draw_y, draw_color,
    output erase_en, draw_en, vga_en, xOutput, yOutput, colorOutput,
           isDrawingDone, busy, timeout_err
  );
endinterface

// File: rtl/tile_refresh_sched.sv
// Frame-refresh scheduler: walks dirty lane lines in ascending order, running
// erase then draw on each, and muxes the active engine onto the VGA port.
module tile_refresh_sched #(
  parameter int TIMEOUT_CYCLES = 16384
) (
  input  logic               clock,
  input  logic               resetn,
  tile_refresh_sched_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ERASE, DRAW, DONE} state_t;

  localparam logic [14:0] WD_LAST = 15'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [5:0]  pending;
  logic [2:0]  row;
  logic [14:0] wd;
  logic        timeout_err_q;

  logic [5:0]  row_sel;
  logic [5:0]  remaining;
  logic        erase_hit;
  logic        draw_hit;
  logic        wd_expired;
  logic [5:0]  x_base;
  logic [5:0]  y_base;

  function automatic logic [2:0] lowest_set(input logic [5:0] mask);
    lowest_set = 3'd0;
    for (int i = 5; i >= 0; i--) begin
      if (mask[i]) lowest_set = 3'(i);
    end
  endfunction

  // Done bits of non-selected lines are masked off here.
  assign row_sel    = 6'b000001 << row;
  assign remaining  = pending & ~row_sel;
  assign erase_hit  = |(bus.erase_done & row_sel);
  assign draw_hit   = |(bus.draw_done & row_sel);
  assign wd_expired = (wd == WD_LAST);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order or other always blocks.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      pending       <= '0;
      row           <= '0;
      wd            <= '0;
      timeout_err_q <= 1'b0;
    end else if (!bus.startn) begin
      state         <= IDLE;
      pending       <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.draw_go) begin
            pending <= bus.dirty_mask;
            wd      <= '0;
            if (bus.dirty_mask == '0) begin
              state <= DONE;
            end else begin
              row   <= lowest_set(bus.dirty_mask);
              state <= ERASE;
            end
          end
        end
        ERASE: begin
          if (erase_hit || wd_expired) begin
            if (!erase_hit) timeout_err_q <= 1'b1;
            wd    <= '0;
            state <= DRAW;
          end else begin
            wd <= wd + 15'd1;
          end
        end
        DRAW: begin
          if (draw_hit || wd_expired) begin
            if (!draw_hit) timeout_err_q <= 1'b1;
            pending <= remaining;
            wd      <= '0;
            if (remaining != '0) begin
              row   <= lowest_set(remaining);
              state <= ERASE;
            end else begin
              state <= DONE;
            end
          end else begin
            wd <= wd + 15'd1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Moore decode straight from the state flops, so the async reset drops
  // every enable without waiting for a clock.
  assign bus.erase_en      = (state == ERASE) ? row_sel : 6'd0;
  assign bus.draw_en       = (state == DRAW)  ? row_sel : 6'd0;
  assign bus.busy          = (state != IDLE);
  assign bus.isDrawingDone = (state == DONE);
  assign bus.timeout_err   = timeout_err_q;

  assign x_base = 6'(row) * 6'd9;
  assign y_base = {row, 3'b000};

  // NOTE: every output gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    bus.vga_en      = 1'b0;
    bus.xOutput     = '0;
    bus.yOutput     = '0;
    bus.colorOutput = '0;
    unique case (state)
      ERASE: begin
        bus.vga_en      = 1'b1;
        bus.xOutput     = bus.erase_x[x_base +: 9];
        bus.yOutput     = bus.erase_y[y_base +: 8];
        bus.colorOutput = |(bus.erase_color & row_sel) ? 3'b000 : 3'b111;
      end
      DRAW: begin
        bus.vga_en      = 1'b1;
        bus.xOutput     = bus.draw_x[x_base +: 9];
        bus.yOutput     = bus.draw_y[y_base +: 8];
        bus.colorOutput = |(bus.draw_color & row_sel) ? 3'b000 : 3'b111;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_tile_refresh_sched.sv
// Self-checking bench for tile_refresh_sched: pixel-mux vector table, directed
// corner sequences, and random frames checked against a schedule model.
module tb_tile_refresh_sched;

  localparam int TMO = 16;

  logic clock = 1'b0;
  logic resetn;

  tile_refresh_sched_if bus ();

  tile_refresh_sched #(.TIMEOUT_CYCLES(TMO)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;
  bit model_err = 1'b0;

  logic [8:0] ex [6];
  logic [8:0] dx [6];
  logic [7:0] ey [6];
  logic [7:0] dy [6];
  logic [5:0] ec;
  logic [5:0] dc;

  typedef struct {
    logic [5:0] een;
    logic [5:0] den;
    int         line;
    bit         fin;       // engine reports done in this cycle
    bit         tmo;       // last cycle of a run that never reports done
    bit         done_cyc;  // frame-complete cycle
  } cyc_t;

  typedef int len_t [6];

  typedef struct {
    int         line;
    logic [8:0] ex;
    logic [7:0] ey;
    logic       ec;
    logic [2:0] exp_ecol;
    logic [8:0] dx;
    logic [7:0] dy;
    logic       dc;
    logic [2:0] exp_dcol;
  } pix_vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic drive_pix();
    for (int k = 0; k < 6; k++) begin
      bus.erase_x[9*k +: 9] = ex[k];
      bus.erase_y[8*k +: 8] = ey[k];
      bus.draw_x[9*k +: 9]  = dx[k];
      bus.draw_y[8*k +: 8]  = dy[k];
    end
    bus.erase_color = ec;
    bus.draw_color  = dc;
  endtask

  task automatic rand_pix();
    for (int k = 0; k < 6; k++) begin
      ex[k] = 9'($urandom_range(0, 319));
      dx[k] = 9'($urandom_range(0, 319));
      ey[k] = 8'($urandom_range(0, 239));
      dy[k] = 8'($urandom_range(0, 239));
    end
    ec = 6'($urandom);
    dc = 6'($urandom);
    drive_pix();
  endtask

  task automatic check_outs(input string tag, input logic [5:0] een, input logic [5:0] den,
                            input logic vga, input logic [8:0] x, input logic [7:0] y,
                            input logic [2:0] c, input logic idd, input logic bsy,
                            input logic err);
    check({tag, " erase_en"},      64'(bus.erase_en),      64'(een));
    check({tag, " draw_en"},       64'(bus.draw_en),       64'(den));
    check({tag, " vga_en"},        64'(bus.vga_en),        64'(vga));
    check({tag, " xOutput"},       64'(bus.xOutput),       64'(x));
    check({tag, " yOutput"},       64'(bus.yOutput),       64'(y));
    check({tag, " colorOutput"},   64'(bus.colorOutput),   64'(c));
    check({tag, " isDrawingDone"}, 64'(bus.isDrawingDone), 64'(idd));
    check({tag, " busy"},          64'(bus.busy),          64'(bsy));
    check({tag, " timeout_err"},   64'(bus.timeout_err),   64'(err));
  endtask

  task automatic quiet_inputs();
    bus.startn     = 1'b1;
    bus.draw_go    = 1'b0;
    bus.erase_done = '0;
    bus.draw_done  = '0;
  endtask

  task automatic idle_cycle(input string tag);
    quiet_inputs();
    @(negedge clock);
    check_outs(tag, 6'd0, 6'd0, 1'b0, 9'd0, 8'd0, 3'd0, 1'b0, 1'b0, model_err);
    @(posedge clock); #1;
  endtask

  task automatic pulse_startn(input string tag);
    quiet_inputs();
    bus.startn = 1'b0;
    @(negedge clock);
    check({tag, " err before abort edge"}, 64'(bus.timeout_err), 64'(model_err));
    @(posedge clock); #1;
    bus.startn = 1'b1;
    model_err  = 1'b0;
    @(negedge clock);
    check({tag, " err cleared"}, 64'(bus.timeout_err), 64'd0);
    check({tag, " busy"},        64'(bus.busy),        64'd0);
    @(posedge clock); #1;
  endtask

  // Expected frame: for each dirty line in ascending order, the erase run then
  // the draw run (a length of 0 means the engine never reports done and the
  // watchdog ends the run after TMO cycles), followed by one DONE cycle.
  task automatic run_frame(input string tag, input logic [5:0] mask,
                           input len_t elen, input len_t dlen, input bit noise);
    cyc_t q[$];
    cyc_t e;
    logic [5:0] sel;
    logic [8:0] xe;
    logic [7:0] ye;
    logic [2:0] ce;
    for (int k = 0; k < 6; k++) begin
      if (mask[k]) begin
        for (int eng = 0; eng < 2; eng++) begin
          int len;
          int n;
          len = (eng == 0) ? elen[k] : dlen[k];
          n   = (len == 0) ? TMO : len;
          for (int j = 0; j < n; j++) begin
            e.een      = (eng == 0) ? 6'(1 << k) : 6'd0;
            e.den      = (eng == 1) ? 6'(1 << k) : 6'd0;
            e.line     = k;
            e.fin      = (len != 0) && (j == n - 1);
            e.tmo      = (len == 0) && (j == n - 1);
            e.done_cyc = 1'b0;
            q.push_back(e);
          end
        end
      end
    end
    e = '{een: 6'd0, den: 6'd0, line: 0, fin: 1'b0, tmo: 1'b0, done_cyc: 1'b1};
    q.push_back(e);

    quiet_inputs();
    bus.draw_go    = 1'b1;
    bus.dirty_mask = mask;
    rand_pix();
    @(posedge clock); #1;
    foreach (q[i]) begin
      e   = q[i];
      sel = e.een | e.den;
      rand_pix();
      bus.dirty_mask = 6'($urandom);
      bus.draw_go    = noise ? 1'($urandom) : 1'b0;
      bus.erase_done = (noise ? (6'($urandom) & ~sel) : 6'd0) | (e.fin ? e.een : 6'd0);
      bus.draw_done  = (noise ? (6'($urandom) & ~sel) : 6'd0) | (e.fin ? e.den : 6'd0);
      @(negedge clock);
      xe = '0; ye = '0; ce = '0;
      if (e.een != 0) begin
        xe = ex[e.line]; ye = ey[e.line]; ce = ec[e.line] ? 3'b000 : 3'b111;
      end else if (e.den != 0) begin
        xe = dx[e.line]; ye = dy[e.line]; ce = dc[e.line] ? 3'b000 : 3'b111;
      end
      check_outs($sformatf("%s c%0d", tag, i), e.een, e.den, sel != 0, xe, ye, ce,
                 e.done_cyc, 1'b1, model_err);
      if (e.tmo) model_err = 1'b1;
      @(posedge clock); #1;
    end
    idle_cycle({tag, " idle"});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL sim_time_limit: run did not reach its summary");
    $fatal(1, "time limit");
  end

  initial begin
    pix_vec_t vt [6];
    len_t l3, el, dl;
    logic [5:0] sel;

    vt[0] = '{3, 9'd17,  8'd5,   1'b0, 3'b111, 9'd200, 8'd100, 1'b1, 3'b000};
    vt[1] = '{3, 9'd200, 8'd100, 1'b1, 3'b000, 9'd200, 8'd100, 1'b0, 3'b111};
    vt[2] = '{0, 9'd0,   8'd0,   1'b1, 3'b000, 9'd319, 8'd239, 1'b0, 3'b111};
    vt[3] = '{5, 9'd319, 8'd239, 1'b0, 3'b111, 9'd1,   8'd1,   1'b1, 3'b000};
    vt[4] = '{1, 9'd256, 8'd128, 1'b1, 3'b000, 9'd255, 8'd127, 1'b0, 3'b111};
    vt[5] = '{4, 9'd85,  8'd170, 1'b0, 3'b111, 9'd170, 8'd85,  1'b1, 3'b000};
    l3 = '{3, 3, 3, 3, 3, 3};

    resetn = 1'b0;
    quiet_inputs();
    bus.dirty_mask = '0;
    rand_pix();
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_outs("reset", 6'd0, 6'd0, 1'b0, 9'd0, 8'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    resetn = 1'b1;
    @(posedge clock); #1;
    idle_cycle("post_reset");

    run_frame("mask000101", 6'b000101, l3, l3, 1'b0);
    run_frame("mask_empty", 6'b000000, l3, l3, 1'b0);

    for (int v = 0; v < 6; v++) begin
      string tag;
      tag = $sformatf("pix%0d", v);
      rand_pix();
      ex[vt[v].line] = vt[v].ex; ey[vt[v].line] = vt[v].ey; ec[vt[v].line] = vt[v].ec;
      dx[vt[v].line] = vt[v].dx; dy[vt[v].line] = vt[v].dy; dc[vt[v].line] = vt[v].dc;
      drive_pix();
      sel = 6'(1 << vt[v].line);
      quiet_inputs();
      bus.draw_go    = 1'b1;
      bus.dirty_mask = sel;
      @(posedge clock); #1;
      quiet_inputs();
      bus.erase_done = sel;
      @(negedge clock);
      check_outs({tag, " erase"}, sel, 6'd0, 1'b1, vt[v].ex, vt[v].ey, vt[v].exp_ecol,
                 1'b0, 1'b1, model_err);
      @(posedge clock); #1;
      quiet_inputs();
      bus.draw_done = sel;
      @(negedge clock);
      check_outs({tag, " draw"}, 6'd0, sel, 1'b1, vt[v].dx, vt[v].dy, vt[v].exp_dcol,
                 1'b0, 1'b1, model_err);
      @(posedge clock); #1;
      quiet_inputs();
      @(negedge clock);
      check_outs({tag, " done"}, 6'd0, 6'd0, 1'b0, 9'd0, 8'd0, 3'd0, 1'b1, 1'b1, model_err);
      @(posedge clock); #1;
      idle_cycle({tag, " idle"});
    end

    // Watchdog: a run ending with done on its last allowed cycle is not a timeout;
    // a line-2 erase that never finishes is, and the frame carries on.
    el = l3; dl = '{1, 1, 1, 1, 1, 1}; el[1] = TMO;
    run_frame("wd_edge", 6'b000010, el, dl, 1'b0);
    el = l3; el[2] = 0;
    run_frame("wd_hang", 6'b000100, el, l3, 1'b0);
    idle_cycle("wd_sticky");
    run_frame("wd_sticky_frame", 6'b100001, l3, l3, 1'b0);
    pulse_startn("wd_clear");

    // Re-request during ERASE is ignored; soft abort mid-DRAW returns to IDLE.
    quiet_inputs();
    bus.draw_go = 1'b1; bus.dirty_mask = 6'b000011;
    @(posedge clock); #1;
    bus.draw_go = 1'b1; bus.dirty_mask = 6'b100000;
    @(negedge clock);
    check("abort erase0", 64'(bus.erase_en), 64'(6'b000001));
    @(posedge clock); #1;
    quiet_inputs(); bus.erase_done = 6'b000001;
    @(negedge clock);
    check("abort still erase0", 64'(bus.erase_en), 64'(6'b000001));
    @(posedge clock); #1;
    quiet_inputs(); bus.draw_done = 6'b000001;
    @(negedge clock);
    check("abort draw0", 64'(bus.draw_en), 64'(6'b000001));
    @(posedge clock); #1;
    quiet_inputs(); bus.erase_done = 6'b000010;
    @(negedge clock);
    check("abort erase1 not line5", 64'(bus.erase_en), 64'(6'b000010));
    @(posedge clock); #1;
    quiet_inputs();
    @(negedge clock);
    check("abort draw1", 64'(bus.draw_en), 64'(6'b000010));
    @(posedge clock); #1;
    bus.startn = 1'b0;
    @(posedge clock); #1;
    for (int i = 0; i < 3; i++) idle_cycle($sformatf("abort idle%0d", i));

    // Asynchronous reset mid-frame drops outputs without a clock edge.
    quiet_inputs();
    bus.draw_go = 1'b1; bus.dirty_mask = 6'b001000;
    @(posedge clock); #1;
    quiet_inputs();
    @(negedge clock);
    check("areset pre erase_en", 64'(bus.erase_en), 64'(6'b001000));
    #1 resetn = 1'b0;
    #1;
    model_err = 1'b0;
    check_outs("areset", 6'd0, 6'd0, 1'b0, 9'd0, 8'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clock);
    @(negedge clock);
    resetn = 1'b1;
    @(posedge clock); #1;
    idle_cycle("areset idle");

    // Random frames with noise on non-selected done lines, draw_go and dirty_mask.
    for (int f = 0; f < 30; f++) begin
      logic [5:0] mask;
      if ($urandom_range(0, 3) == 0) pulse_startn($sformatf("rnd%0d abort", f));
      mask = 6'($urandom);
      for (int k = 0; k < 6; k++) begin
        el[k] = ($urandom_range(0, 19) == 0) ? 0 : int'($urandom_range(1, 5));
        dl[k] = ($urandom_range(0, 19) == 0) ? 0 : int'($urandom_range(1, 5));
      end
      run_frame($sformatf("rnd%0d", f), mask, el, dl, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
